// File: rtl/cache_tag_array.sv
// cache_tag_array: WAYS x LINES tag store for the instruction and data caches.
//
// Port A serves pipelined lookups. Stage 1 reads all ways of the line. Stage 2 presents
// hit_valid/hit/hit_way/victim_way. A fill to the same line in the same cycle is bypassed
// into stage 2.
// Port B is shared by three agents, highest priority first:
//   - the invalidate walker (runs after reset and on flush_req);
//   - fills;
//   - a buffered external-invalidation queue (read cycle, then compare/write cycle).
//
// Ports:
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   lookup_en_i, lookup_addr_i      stage-1 lookup (accepted while ready_o)
//   ready_o                         no walk in progress
//   hit_valid_o, hit_o, hit_way_o   stage-2 lookup result
//   victim_way_o                    one-hot replacement way for the stage-2 line
//   fill_en_i, fill_addr_i,
//   fill_way_i                      tag write of a valid entry
//   flush_req_i, flush_done_o       full invalidation request / completion pulse
//   inv_valid_i, inv_addr_i,
//   inv_ready_o, inv_busy_o         external invalidation queue
//   parity_err_o                    stage-2 parity error (CACHE_TAG_PARITY_EN only)
//
// Build option: define CACHE_TAG_PARITY_EN to store an even-parity bit per entry.
module cache_tag_array #(
    parameter int unsigned WAYS       = 2,
    parameter int unsigned LINES      = 512,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned INV_DEPTH  = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            lookup_en_i,
    input  logic [31:0]     lookup_addr_i,
    output logic            ready_o,
    output logic            hit_valid_o,
    output logic            hit_o,
    output logic [WAYS-1:0] hit_way_o,
    output logic [WAYS-1:0] victim_way_o,
    input  logic            fill_en_i,
    input  logic [31:0]     fill_addr_i,
    input  logic [WAYS-1:0] fill_way_i,
    input  logic            flush_req_i,
    output logic            flush_done_o,
    input  logic            inv_valid_i,
    input  logic [31:0]     inv_addr_i,
    output logic            inv_ready_o,
    output logic            inv_busy_o
`ifdef CACHE_TAG_PARITY_EN
    ,
    output logic            parity_err_o
`endif
);

    localparam int unsigned LINE_ADDR_W = $clog2(LINES);
    localparam int unsigned SUB_W       = $clog2(LINE_WORDS);
    localparam int unsigned TAG_W       = 30 - LINE_ADDR_W - SUB_W;
    localparam int unsigned LOW_W       = 2 + SUB_W;
    localparam int unsigned KEY_W       = TAG_W + LINE_ADDR_W;
`ifdef CACHE_TAG_PARITY_EN
    localparam int unsigned ENTRY_W     = TAG_W + 2;
`else
    localparam int unsigned ENTRY_W     = TAG_W + 1;
`endif
    localparam int unsigned RR_W        = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned IPTR_W      = $clog2(INV_DEPTH);
    localparam int unsigned ICNT_W      = IPTR_W + 1;

    // Entry layout: [TAG_W-1:0] tag, [TAG_W] valid, [TAG_W+1] parity (optional).

    typedef enum logic [0:0] {StWalk, StIdle} walk_st_e;
    typedef enum logic [0:0] {InvRead, InvCmp} inv_st_e;

    // Address decode
    logic [LINE_ADDR_W-1:0] lk_line, fill_line, head_line;
    logic [TAG_W-1:0]       lk_tag, fill_tag, head_tag;
    logic [ENTRY_W-1:0]     fill_entry;
    logic                   unused_low_bits;

    assign lk_line   = lookup_addr_i[LOW_W +: LINE_ADDR_W];
    assign lk_tag    = lookup_addr_i[31 -: TAG_W];
    assign fill_line = fill_addr_i[LOW_W +: LINE_ADDR_W];
    assign fill_tag  = fill_addr_i[31 -: TAG_W];
    assign unused_low_bits = ^{lookup_addr_i[LOW_W-1:0], fill_addr_i[LOW_W-1:0],
                               inv_addr_i[LOW_W-1:0]};

`ifdef CACHE_TAG_PARITY_EN
    assign fill_entry = {^{1'b1, fill_tag}, 1'b1, fill_tag};
`else
    assign fill_entry = {1'b1, fill_tag};
`endif

    // Walker FSM
    walk_st_e               walk_st_q, walk_st_d;
    logic [LINE_ADDR_W-1:0] walk_line_q, walk_line_d;
    logic                   walk_flush_q, walk_flush_d;
    logic                   flush_done_q, flush_done_d;
    logic                   walking;

    assign walking = (walk_st_q == StWalk);

    always_comb begin
        walk_st_d    = walk_st_q;
        walk_line_d  = walk_line_q;
        walk_flush_d = walk_flush_q;
        flush_done_d = 1'b0;
        unique case (walk_st_q)
            StWalk: begin
                walk_line_d = walk_line_q + 1'b1;
                if (walk_line_q == LINE_ADDR_W'(LINES - 1)) begin
                    walk_st_d    = StIdle;
                    // The walk that follows reset completes silently.
                    flush_done_d = walk_flush_q;
                end
            end
            StIdle: begin
                if (flush_req_i) begin
                    walk_st_d    = StWalk;
                    walk_line_d  = '0;
                    walk_flush_d = 1'b1;
                end
            end
            default: walk_st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            walk_st_q    <= StWalk;
            walk_line_q  <= '0;
            walk_flush_q <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            walk_st_q    <= walk_st_d;
            walk_line_q  <= walk_line_d;
            walk_flush_q <= walk_flush_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign ready_o      = ~walking;
    assign flush_done_o = flush_done_q;

    // Invalidation FIFO, stores {tag, line}
    logic [KEY_W-1:0]  inv_fifo_q [INV_DEPTH];
    logic [IPTR_W-1:0] inv_wr_q, inv_rd_q;
    logic [ICNT_W-1:0] inv_cnt_q, inv_cnt_d;
    logic              inv_ready_q;
    logic              inv_push, inv_pop;
    logic [KEY_W-1:0]  head_key;

    assign inv_push  = inv_valid_i & inv_ready_q;
    assign head_key  = inv_fifo_q[inv_rd_q];
    assign head_line = head_key[LINE_ADDR_W-1:0];
    assign head_tag  = head_key[KEY_W-1 -: TAG_W];

    always_comb begin
        inv_cnt_d = inv_cnt_q;
        if (inv_push && !inv_pop) begin
            inv_cnt_d = inv_cnt_q + 1'b1;
        end else if (!inv_push && inv_pop) begin
            inv_cnt_d = inv_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (inv_push) begin
            inv_fifo_q[inv_wr_q] <= inv_addr_i[31:LOW_W];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inv_wr_q    <= '0;
            inv_rd_q    <= '0;
            inv_cnt_q   <= '0;
            inv_ready_q <= 1'b0;
        end else begin
            if (inv_push) inv_wr_q <= inv_wr_q + 1'b1;
            if (inv_pop)  inv_rd_q <= inv_rd_q + 1'b1;
            inv_cnt_q   <= inv_cnt_d;
            inv_ready_q <= (inv_cnt_d != ICNT_W'(INV_DEPTH));
        end
    end

    assign inv_ready_o = inv_ready_q;
    assign inv_busy_o  = (inv_cnt_q != '0);

    // Port B arbitration and invalidation sequencing
    inv_st_e                inv_st_q, inv_st_d;
    logic [WAYS-1:0]        b_we;
    logic                   b_re;
    logic [LINE_ADDR_W-1:0] b_line;
    logic [ENTRY_W-1:0]     b_wdata;
    logic [WAYS-1:0]        inv_hit;
    logic [ENTRY_W-1:0]     rd_b_q [WAYS];

    always_comb begin
        inv_hit = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            inv_hit[w] = rd_b_q[w][TAG_W] && (rd_b_q[w][TAG_W-1:0] == head_tag);
        end
    end

    always_comb begin
        b_we     = '0;
        b_re     = 1'b0;
        b_line   = walk_line_q;
        b_wdata  = '0;
        inv_pop  = 1'b0;
        inv_st_d = inv_st_q;
        if (walking) begin
            b_we     = '1;
            inv_st_d = InvRead;
        end else if (fill_en_i) begin
            // A fill steals port B; the head invalidation re-reads afterwards.
            b_we     = fill_way_i;
            b_line   = fill_line;
            b_wdata  = fill_entry;
            inv_st_d = InvRead;
        end else if (inv_cnt_q != '0) begin
            b_line = head_line;
            unique case (inv_st_q)
                InvRead: begin
                    b_re     = 1'b1;
                    inv_st_d = InvCmp;
                end
                InvCmp: begin
                    b_we     = inv_hit;
                    inv_pop  = 1'b1;
                    inv_st_d = InvRead;
                end
                default: inv_st_d = InvRead;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inv_st_q <= InvRead;
        end else begin
            inv_st_q <= inv_st_d;
        end
    end

    // Tag RAM (no reset; the walker initialises it)
    logic [ENTRY_W-1:0] mem_q [WAYS][LINES];

    always_ff @(posedge clk_i) begin
        for (int w = 0; w < int'(WAYS); w++) begin
            if (b_we[w]) mem_q[w][b_line] <= b_wdata;
            if (b_re)    rd_b_q[w] <= mem_q[w][b_line];
        end
    end

    // Lookup pipeline
    logic                lk_acc;
    logic [ENTRY_W-1:0]  s2_entry_d [WAYS];
    logic [ENTRY_W-1:0]  s2_entry_q [WAYS];
    logic [TAG_W-1:0]    s2_tag_q;
    logic                s2_valid_q;
    logic [RR_W-1:0]     rr_q, rr_d;

    assign lk_acc = lookup_en_i & ready_o;

    always_comb begin
        for (int w = 0; w < int'(WAYS); w++) begin
            s2_entry_d[w] = mem_q[w][lk_line];
            if (fill_en_i && !walking && fill_way_i[w] && (fill_line == lk_line)) begin
                s2_entry_d[w] = fill_entry;
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (fill_en_i) begin
            rr_d = (rr_q == RR_W'(WAYS - 1)) ? '0 : rr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid_q <= 1'b0;
            s2_tag_q   <= '0;
            rr_q       <= '0;
            for (int w = 0; w < int'(WAYS); w++) begin
                s2_entry_q[w] <= '0;
            end
        end else begin
            s2_valid_q <= lk_acc;
            rr_q       <= rr_d;
            if (lk_acc) begin
                s2_tag_q   <= lk_tag;
                s2_entry_q <= s2_entry_d;
            end
        end
    end

    // Stage 2: compare and victim selection
    logic [WAYS-1:0] way_ok, match, perr, victim;
    logic            victim_found;

    always_comb begin
        way_ok = '0;
        match  = '0;
        perr   = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
`ifdef CACHE_TAG_PARITY_EN
            perr[w] = ^s2_entry_q[w];
`endif
            way_ok[w] = s2_entry_q[w][TAG_W] & ~perr[w];
            match[w]  = way_ok[w] & (s2_entry_q[w][TAG_W-1:0] == s2_tag_q);
        end
    end

    always_comb begin
        victim       = '0;
        victim_found = 1'b0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (!victim_found && !way_ok[w]) begin
                victim[w]    = 1'b1;
                victim_found = 1'b1;
            end
        end
        if (!victim_found) begin
            victim = WAYS'(1) << rr_q;
        end
    end

    assign hit_valid_o  = s2_valid_q;
    assign hit_way_o    = s2_valid_q ? match : '0;
    assign hit_o        = |hit_way_o;
    assign victim_way_o = s2_valid_q ? victim : '0;
`ifdef CACHE_TAG_PARITY_EN
    assign parity_err_o = s2_valid_q & (|perr);
`endif

endmodule

// File: tb/tb_cache_tag_array.sv
// Self-checking bench for cache_tag_array (WAYS=2, LINES=16, LINE_WORDS=4, INV_DEPTH=4).
// Address map here: line = addr[7:4], tag = addr[31:8].
module tb_cache_tag_array;
    localparam int WAYS       = 2;
    localparam int LINES      = 16;
    localparam int LINE_WORDS = 4;
    localparam int INV_DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lookup_en = 1'b0;
    logic [31:0] lookup_addr = '0;
    logic        ready, hit_valid, hit;
    logic [1:0]  hit_way, victim_way;
    logic        fill_en = 1'b0;
    logic [31:0] fill_addr = '0;
    logic [1:0]  fill_way = '0;
    logic        flush_req = 1'b0;
    logic        flush_done;
    logic        inv_valid = 1'b0;
    logic [31:0] inv_addr = '0;
    logic        inv_ready, inv_busy;

    always #5 clk = ~clk;

    cache_tag_array #(
        .WAYS       (WAYS),
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS),
        .INV_DEPTH  (INV_DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .lookup_en_i   (lookup_en),
        .lookup_addr_i (lookup_addr),
        .ready_o       (ready),
        .hit_valid_o   (hit_valid),
        .hit_o         (hit),
        .hit_way_o     (hit_way),
        .victim_way_o  (victim_way),
        .fill_en_i     (fill_en),
        .fill_addr_i   (fill_addr),
        .fill_way_i    (fill_way),
        .flush_req_i   (flush_req),
        .flush_done_o  (flush_done),
        .inv_valid_i   (inv_valid),
        .inv_addr_i    (inv_addr),
        .inv_ready_o   (inv_ready),
        .inv_busy_o    (inv_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic       hit;
        logic [1:0] way;
        logic [1:0] victim;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model: plain arrays of valid bits and tags, plus a fill counter for round-robin.
    bit          mv [WAYS][LINES];
    logic [23:0] mt [WAYS][LINES];
    int          rr;

    logic [31:0] inv_list [4];
    logic [31:0] fa [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int line_of(input logic [31:0] a);
        return int'(a[7:4]);
    endfunction

    function automatic logic [31:0] mk_addr(input logic [23:0] t, input int ln);
        logic [3:0] lo;
        lo = 4'($urandom_range(0, 15));
        return {t, 4'(ln), lo};
    endfunction

    function automatic void model_clear();
        for (int w = 0; w < WAYS; w++)
            for (int l = 0; l < LINES; l++) begin
                mv[w][l] = 1'b0;
                mt[w][l] = '0;
            end
    endfunction

    function automatic void model_fill(input logic [31:0] a, input logic [1:0] way);
        for (int w = 0; w < WAYS; w++)
            if (way[w]) begin
                mv[w][line_of(a)] = 1'b1;
                mt[w][line_of(a)] = a[31:8];
            end
    endfunction

    function automatic void model_inv(input logic [31:0] a);
        for (int w = 0; w < WAYS; w++)
            if (mv[w][line_of(a)] && mt[w][line_of(a)] == a[31:8]) mv[w][line_of(a)] = 1'b0;
    endfunction

    function automatic exp_t model_lookup(input logic [31:0] a);
        exp_t e;
        bit   found;
        int   ln;
        ln = line_of(a);
        e = '0;
        found = 1'b0;
        for (int w = 0; w < WAYS; w++)
            if (mv[w][ln] && mt[w][ln] == a[31:8]) e.way[w] = 1'b1;
        e.hit = |e.way;
        for (int w = 0; w < WAYS; w++)
            if (!found && !mv[w][ln]) begin
                e.victim[w] = 1'b1;
                found = 1'b1;
            end
        if (!found) e.victim[rr] = 1'b1;
        return e;
    endfunction

    // Applies this cycle's requests to the model, then advances one clock.
    task automatic tick();
        if (fill_en) begin
            if (ready) model_fill(fill_addr, fill_way);
            rr = (rr + 1) % WAYS;
        end
        if (lookup_en && ready) exp_q.push_back(model_lookup(lookup_addr));
        if (flush_req && ready) model_clear();
        if (inv_valid && inv_ready) model_inv(inv_addr);
        @(posedge clk);
        #1;
        lookup_en = 1'b0;
        fill_en   = 1'b0;
        flush_req = 1'b0;
        inv_valid = 1'b0;
    endtask

    task automatic do_lookup(input logic [31:0] a);
        lookup_en   = 1'b1;
        lookup_addr = a;
        tick();
    endtask

    task automatic do_fill(input logic [31:0] a, input logic [1:0] way);
        fill_en   = 1'b1;
        fill_addr = a;
        fill_way  = way;
        tick();
    endtask

    task automatic wait_ready(input int limit, output int n_low, output int n_done);
        n_low  = 0;
        n_done = 0;
        while (!ready && n_low < limit) begin
            if (flush_done) n_done++;
            n_low++;
            tick();
        end
        if (flush_done) n_done++;
        if (!ready) check("ready_timeout", ready, 1);
    endtask

    task automatic wait_inv_idle(input int limit);
        int n;
        n = 0;
        while (inv_busy && n < limit) begin
            n++;
            tick();
        end
        check("inv_drain", inv_busy, 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", ready, 0);
        check("rst_hit_valid", hit_valid, 0);
        check("rst_hit", hit, 0);
        check("rst_hit_way", hit_way, 0);
        check("rst_victim", victim_way, 0);
        check("rst_flush_done", flush_done, 0);
        check("rst_inv_ready", inv_ready, 0);
        check("rst_inv_busy", inv_busy, 0);
    endtask

    // Monitor: every presented result is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && hit_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_hit_valid", hit_valid, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("hit", hit, mon_e.hit);
                check("hit_way", hit_way, mon_e.way);
                check("victim_way", victim_way, mon_e.victim);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nl, nd;
        logic [1:0] w2;
        model_clear();
        rr = 0;
        inv_list[0] = 32'h1234_5670;
        inv_list[1] = 32'h5555_5550;
        inv_list[2] = 32'h0000_0100;
        inv_list[3] = 32'hBBBB_0030;

        // Reset and the silent reset walk
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        wait_ready(100, nl, nd);
        check("reset_walk_cycles", nl, LINES);
        check("reset_walk_done_pulses", nd, 0);

        do_lookup(32'h0000_0100);

        // Fill then hit; same line with another tag misses
        do_fill(32'h1234_5670, 2'b10);
        do_lookup(32'h1234_5670);
        do_lookup(32'h2234_5670);

        // Round-robin once both ways of line 3 are valid
        do_fill(32'hAAAA_0030, 2'b01);
        do_fill(32'hBBBB_0030, 2'b10);
        do_lookup(32'hCCCC_0030);
        for (int i = 0; i < 3; i++) begin
            w2 = (rr == 0) ? 2'b01 : 2'b10;
            do_fill(mk_addr(24'hD0_0000 + 24'(i), 3), w2);
            do_lookup(32'hCCCC_0030);
        end

        // Same-cycle lookup and fill to line 5
        lookup_en   = 1'b1;
        lookup_addr = 32'h5555_5550;
        fill_en     = 1'b1;
        fill_addr   = 32'h5555_5554;
        fill_way    = 2'b01;
        tick();
        do_lookup(32'h5555_5558);

        // Invalidation queue: fills on line 9 hold port B until the queue is full
        check("inv_ready_empty", inv_ready, 1);
        for (int i = 0; i < 4; i++) begin
            inv_valid = 1'b1;
            inv_addr  = inv_list[i];
            w2 = (i % 2 == 0) ? 2'b01 : 2'b10;
            do_fill(mk_addr(24'h00_9990 + 24'(i), 9), w2);
        end
        check("inv_ready_full", inv_ready, 0);
        check("inv_busy_full", inv_busy, 1);
        tick();                                   // head read
        do_fill(32'h9999_A090, 2'b01);            // aborts the head compare
        wait_inv_idle(40);
        for (int i = 0; i < 4; i++) do_lookup(inv_list[i]);
        do_lookup(32'h9999_A090);
        do_lookup(mk_addr(24'h00_9993, 9));

        // Populate 8 lines, flush, queued invalidation resumes afterwards
        for (int i = 0; i < 8; i++) begin
            fa[i] = mk_addr(24'($urandom), i);
            w2 = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            do_fill(fa[i], w2);
        end
        for (int i = 0; i < 8; i++) do_lookup(fa[i]);
        flush_req = 1'b1;
        tick();
        inv_valid = 1'b1;
        inv_addr  = fa[2];
        wait_ready(100, nl, nd);
        check("flush_walk_cycles", nl, LINES);
        check("flush_done_pulses", nd, 1);
        tick();
        check("flush_done_single", flush_done, 0);
        wait_inv_idle(20);
        for (int i = 0; i < 8; i++) do_lookup(fa[i]);

        // Randomised mix of lookups and fills on a small address pool
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                lookup_en   = 1'b1;
                lookup_addr = mk_addr(24'($urandom_range(0, 2)), $urandom_range(0, 3));
            end
            if ($urandom_range(0, 2) == 0) begin
                fill_en   = 1'b1;
                fill_addr = mk_addr(24'($urandom_range(0, 2)), $urandom_range(0, 3));
                fill_way  = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            end
            tick();
        end
        tick();

        // Asynchronous reset in the middle of a flush walk with a queued invalidation
        do_fill(32'h7777_00F0, 2'b01);
        flush_req = 1'b1;
        tick();
        inv_valid = 1'b1;
        inv_addr  = 32'h7777_00F0;
        tick();
        tick();
        rst_n = 1'b0;
        #2;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
        rr = 0;
        wait_ready(100, nl, nd);
        check("rewalk_cycles", nl, LINES);
        check("rewalk_done_pulses", nd, 0);
        check("rewalk_inv_busy", inv_busy, 0);
        do_lookup(32'h7777_00F0);
        do_lookup(32'h1234_5670);
        tick();
        tick();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_tag_array.md
Name: cache_tag_array

Overview:
- Parametrised next-generation tag store for the instruction and data caches.
- Holds WAYS x LINES tag entries in dual-port tag RAM:
  - port A: pipelined lookups;
  - port B: fills, queued external invalidations and a sequenced full flush.
- Adds replacement-way selection, a self-clearing reset/flush walker and a buffered invalidation queue.
- Sits between the fetch/load stage-1 address and the miss/fill controller.

Parameters:
- WAYS, 2, number of ways (1..8).
- LINES, 512, lines per way (power of two, >=2); LINE_ADDR_W = log2(LINES).
- LINE_WORDS, 4, 32-bit words per line (power of two); SUB_W = log2(LINE_WORDS).
- INV_DEPTH, 4, external-invalidation FIFO entries (power of two, >=2).
- Derived: TAG_W = 30 - LINE_ADDR_W - SUB_W.
- Address mapping:
  - line = addr[2+SUB_W +: LINE_ADDR_W];
  - tag = addr[31 -: TAG_W].

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- lookup_en  in  1  stage-1 lookup request; accepted only when ready=1
- lookup_addr  in  32  stage-1 address
- ready  out  1  array idle (not flushing); lookups accepted
- hit_valid  out  1  stage-2 result valid (registered lookup_en & ready)
- hit  out  1  OR of hit_way, qualified by hit_valid
- hit_way  out  WAYS  one-hot hit vector, qualified by hit_valid
- victim_way  out  WAYS  one-hot way to replace for the stage-2 address
- fill_en  in  1  write a valid tag for fill_addr into fill_way
- fill_addr  in  32  fill address
- fill_way  in  WAYS  one-hot target way
- flush_req  in  1  start full invalidation, pulse
- flush_done  out  1  one-cycle pulse when a flush walk finishes
- inv_valid  in  1  external invalidation request
- inv_addr  in  32  address to invalidate
- inv_ready  out  1  FIFO not full
- inv_busy  out  1  FIFO non-empty or invalidation in flight

Behaviour:
- Reset (rst=0):
  - all outputs 0; FIFO empty; round-robin pointer = way 0.
  - On release, the walker starts automatically: it writes invalid entries to line 0..LINES-1 on port B, all ways, one line per cycle.
  - ready rises the cycle after line LINES-1 is written. flush_done does not pulse for the reset walk.
- flush_req while ready=1:
  - same walk; ready=0 for LINES cycles; flush_done pulses with ready's rise.
  - flush_req during a walk is ignored.
- Lookup: hit_valid/hit/hit_way appear exactly 1 cycle after an accepted lookup_en. hit_way[i] = entry valid and tag equal.
- Fill bypass: a fill writing the same line in the same cycle as the lookup read forces stage 2 to see the new entry for fill_way and the old entries for the other ways.
- victim_way, from the stage-2 registered entries:
  - lowest-index invalid way, if any;
  - otherwise the round-robin pointer.
  - The pointer advances (mod WAYS) on every fill_en.
- Port-B priority: walker > fill > external invalidation.
  - A fill during a walk is dropped; the miss controller must not fill while ready=0.
- External invalidation:
  - Push when inv_valid & inv_ready.
  - Head entry processing: cycle 1 reads the line on port B; cycle 2 compares and writes invalid to every hit way, then pops.
  - A fill in either cycle aborts and restarts the head from cycle 1.
  - The walker pauses the queue; the queue resumes after the walk, and entries are not discarded.
  - Full: inv_ready=0. Pointers wrap mod INV_DEPTH.
  - Push and pop in the same cycle while full are allowed only if the pop occurs (ready reflects the registered count).
- Async reset mid-walk or mid-invalidation: everything restarts from the reset state.

Optional Feature:
- CACHE_TAG_PARITY_EN defined:
  - each entry stores an even-parity bit over {valid, tag};
  - a stage-2 parity mismatch forces that way's hit_way bit to 0 and marks it invalid for victim selection;
  - adds output parity_err (1, registered with hit_valid).
- Not defined: no parity bit, no parity_err port, RAM width TAG_W+1.

Test Plan:
- Reset release, LINES=16 -> ready=0 for 16 cycles then 1; a lookup of 0x0000_0100 gives hit_valid=1, hit=0, victim_way=0001.
- Fill 0x1234_5670 into way 1, then look up the same address -> next cycle hit=1, hit_way=0010. Look up 0x2234_5670 (same line, other tag) -> hit=0, victim_way=0001.
- Fill all 2 ways of a line, then three further fills -> round-robin victim_way sequence 01,10,01.
- Queue 4 invalidations with inv_valid held -> inv_ready=0 after the 4th. Each hit entry is cleared 2 cycles after reaching the head. A fill injected mid-invalidation -> that invalidation restarts and still clears its entry.
- flush_req after populating 8 lines -> ready=0 for LINES cycles, flush_done single pulse, all subsequent lookups miss. A queued invalidation resumes afterwards and inv_busy falls.
- Lookup and fill to the same line in the same cycle -> stage-2 hit=1 on fill_way.
